pipeline_hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the SPU core: ID-stage unit driving stall, bubble, flush and operand-forward selects.

---
 rtl/spu_hazard_pkg.sv | 18 +
 rtl/hazard_fwd_sel.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spu_hazard_pkg.sv
// Shared types for the SPU ID-stage hazard controller.
package spu_hazard_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        MUL_WAIT  = 2'b10
    } hz_state_e;

    // Operand forward select encoding seen by the EX operand muxes.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_EX  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select decode for one source operand: EX result beats MEM result,
// register 0 is never forwarded and a load in EX has no result to forward yet.
module hazard_fwd_sel
    import spu_hazard_pkg::*;
#(
    parameter int unsigned REG_W = 7
) (
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] rd_ex_i,
    input  logic             reg_write_ex_i,
    input  logic             mem_read_ex_i,
    input  logic [REG_W-1:0] rd_mem_i,
    input  logic             reg_write_mem_i,
    output fwd_sel_e         fwd_sel_o
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = reg_write_ex_i && !mem_read_ex_i && (rd_ex_i != '0) && (rd_ex_i == src_i);
    assign mem_hit = reg_write_mem_i && (rd_mem_i != '0) && (rd_mem_i == src_i);

    // Priority select: youngest producer wins.
    always_comb begin
        fwd_sel_o = FWD_RF;
        if (ex_hit) begin
            fwd_sel_o = FWD_EX;
        end else if (mem_hit) begin
            fwd_sel_o = FWD_MEM;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage hazard controller: load-use and multiply-busy stalls held by a
// small FSM/counter, taken-branch flush, and EX/MEM operand forward selects.
module pipeline_hazard_ctrl
    import spu_hazard_pkg::*;
#(
    parameter int unsigned REG_W    = 7,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MUL_LAT  = 4,
    parameter int unsigned CNT_W    =
        $clog2(((LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT) + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             UsesRs_ID,
    input  logic             UsesRt_ID,
    input  logic [REG_W-1:0] Rd_EX,
    input  logic             RegWrite_EX,
    input  logic             MemRead_EX,
    input  logic             MulStart_EX,
    input  logic             BranchTaken_EX,
    input  logic [REG_W-1:0] Rd_MEM,
    input  logic             RegWrite_MEM,
    output logic             Stall_FE,
    output logic             Stall_EX,
    output logic             Bubble_EX,
    output logic             Flush_IFID,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic [CNT_W-1:0] StallCnt
);

    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
    localparam logic [CNT_W-1:0] LoadWaitCnt = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] MulWaitCnt  = CNT_W'(MUL_LAT - 2);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic     lu_hit;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    // Load-use: the ID instruction needs a value the load in EX has not fetched yet.
    assign lu_hit = MemRead_EX && RegWrite_EX && (Rd_EX != '0) &&
                    ((UsesRs_ID && (Rs_ID == Rd_EX)) || (UsesRt_ID && (Rt_ID == Rd_EX)));

    hazard_fwd_sel #(
        .REG_W (REG_W)
    ) u_fwd_a (
        .src_i           (Rs_ID),
        .rd_ex_i         (Rd_EX),
        .reg_write_ex_i  (RegWrite_EX),
        .mem_read_ex_i   (MemRead_EX),
        .rd_mem_i        (Rd_MEM),
        .reg_write_mem_i (RegWrite_MEM),
        .fwd_sel_o       (fwd_a)
    );

    hazard_fwd_sel #(
        .REG_W (REG_W)
    ) u_fwd_b (
        .src_i           (Rt_ID),
        .rd_ex_i         (Rd_EX),
        .reg_write_ex_i  (RegWrite_EX),
        .mem_read_ex_i   (MemRead_EX),
        .rd_mem_i        (Rd_MEM),
        .reg_write_mem_i (RegWrite_MEM),
        .fwd_sel_o       (fwd_b)
    );

    // Next-state and stall/flush decode; reset freezes the whole pipe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        Stall_FE   = 1'b0;
        Stall_EX   = 1'b0;
        Bubble_EX  = 1'b0;
        Flush_IFID = 1'b0;
        if (!Reset) begin
            Stall_FE = 1'b1;
            Stall_EX = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (BranchTaken_EX) begin
                        // Wrong-path instructions in IF/ID are squashed; hazards on them are moot.
                        Flush_IFID = 1'b1;
                        Bubble_EX  = 1'b1;
                    end else if (MulStart_EX) begin
                        Stall_FE = 1'b1;
                        Stall_EX = 1'b1;
                        if (MUL_LAT - 1 > 1) begin
                            state_d = MUL_WAIT;
                            cnt_d   = MulWaitCnt;
                        end
                    end else if (lu_hit) begin
                        Stall_FE  = 1'b1;
                        Bubble_EX = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = LOAD_WAIT;
                            cnt_d   = LoadWaitCnt;
                        end
                    end
                end
                LOAD_WAIT: begin
                    Stall_FE  = 1'b1;
                    Bubble_EX = 1'b1;
                    if (cnt_q == CntOne) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                MUL_WAIT: begin
                    // EX is held, so new EX-side events cannot be acted on here.
                    Stall_FE = 1'b1;
                    Stall_EX = 1'b1;
                    if (cnt_q == CntOne) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers; reset is folded into the next-state logic.
    always_ff @(posedge Clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    // Forward selects and debug counter view.
    always_comb begin
        FwdA     = Reset ? fwd_a : FWD_RF;
        FwdB     = Reset ? fwd_b : FWD_RF;
        StallCnt = (state_q == IDLE) ? '0 : cnt_q;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (LOAD_LAT=3, MUL_LAT=4).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_W    = 7;
    localparam int unsigned LOAD_LAT = 3;
    localparam int unsigned MUL_LAT  = 4;
    localparam int unsigned CNT_W    = 3;

    logic             clk;
    logic             rst_n;
    logic [REG_W-1:0] rs_id, rt_id, rd_ex, rd_mem;
    logic             uses_rs, uses_rt, reg_write_ex, mem_read_ex, mul_start, br_taken;
    logic             reg_write_mem;
    logic             stall_fe, stall_ex, bubble_ex, flush_ifid;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    typedef struct {
        string      tag;
        logic       sfe;
        logic       sex;
        logic       bub;
        logic       fl;
        logic [1:0] fa;
        logic [1:0] fb;
        int         cnt;   // -1: not checked
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    pipeline_hazard_ctrl #(
        .REG_W    (REG_W),
        .LOAD_LAT (LOAD_LAT),
        .MUL_LAT  (MUL_LAT)
    ) dut (
        .Clk            (clk),
        .Reset          (rst_n),
        .Rs_ID          (rs_id),
        .Rt_ID          (rt_id),
        .UsesRs_ID      (uses_rs),
        .UsesRt_ID      (uses_rt),
        .Rd_EX          (rd_ex),
        .RegWrite_EX    (reg_write_ex),
        .MemRead_EX     (mem_read_ex),
        .MulStart_EX    (mul_start),
        .BranchTaken_EX (br_taken),
        .Rd_MEM         (rd_mem),
        .RegWrite_MEM   (reg_write_mem),
        .Stall_FE       (stall_fe),
        .Stall_EX       (stall_ex),
        .Bubble_EX      (bubble_ex),
        .Flush_IFID     (flush_ifid),
        .FwdA           (fwd_a),
        .FwdB           (fwd_b),
        .StallCnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation, away from the edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq({e.tag, ".stall_fe"}, int'(stall_fe), int'(e.sfe));
            check_eq({e.tag, ".stall_ex"}, int'(stall_ex), int'(e.sex));
            check_eq({e.tag, ".bubble"},   int'(bubble_ex), int'(e.bub));
            check_eq({e.tag, ".flush"},    int'(flush_ifid), int'(e.fl));
            check_eq({e.tag, ".fwd_a"},    int'(fwd_a), int'(e.fa));
            check_eq({e.tag, ".fwd_b"},    int'(fwd_b), int'(e.fb));
            if (e.cnt >= 0) check_eq({e.tag, ".cnt"}, int'(stall_cnt), e.cnt);
        end
    end

    // Push the expectation for the inputs currently driven, then advance one cycle.
    task automatic exp_cyc(input string tag, input logic sfe, input logic sex, input logic bub,
                           input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                           input int cnt);
        exp_t e;
        e.tag = tag; e.sfe = sfe; e.sex = sex; e.bub = bub; e.fl = fl;
        e.fa = fa; e.fb = fb; e.cnt = cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1;
        rs_id = '0; rt_id = '0; rd_ex = '0; rd_mem = '0;
        uses_rs = 1'b0; uses_rt = 1'b0; reg_write_ex = 1'b0; mem_read_ex = 1'b0;
        mul_start = 1'b0; br_taken = 1'b0; reg_write_mem = 1'b0;
    endtask

    task automatic load_on(input logic [REG_W-1:0] rd);
        rd_ex = rd; reg_write_ex = 1'b1; mem_read_ex = 1'b1;
    endtask

    initial begin
        idle_inputs();
        // Reset held with hazards of every kind on the inputs.
        rst_n = 1'b0;
        rs_id = 7'd5; rt_id = 7'd3; uses_rs = 1'b1; uses_rt = 1'b1;
        load_on(7'd5); mul_start = 1'b1; br_taken = 1'b1;
        rd_mem = 7'd3; reg_write_mem = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) exp_cyc($sformatf("rst%0d", i), 1, 1, 0, 0, 2'b00, 2'b00, -1);
        idle_inputs();
        exp_cyc("rst_rel", 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Load-use on Rs: 3 stall cycles, counter 0,2,1, then MEM forward.
        rs_id = 7'd5; uses_rs = 1'b1; load_on(7'd5);
        exp_cyc("lu_c0", 1, 0, 1, 0, 2'b00, 2'b00, 0);
        exp_cyc("lu_c1", 1, 0, 1, 0, 2'b00, 2'b00, 2);
        exp_cyc("lu_c2", 1, 0, 1, 0, 2'b00, 2'b00, 1);
        reg_write_ex = 1'b0; mem_read_ex = 1'b0; rd_ex = '0;
        rd_mem = 7'd5; reg_write_mem = 1'b1;
        exp_cyc("lu_done", 0, 0, 0, 0, 2'b01, 2'b00, 0);

        // Load-use on Rt only.
        idle_inputs();
        rt_id = 7'd12; uses_rt = 1'b1; rs_id = 7'd4; uses_rs = 1'b1; load_on(7'd12);
        exp_cyc("lut_c0", 1, 0, 1, 0, 2'b00, 2'b00, 0);
        exp_cyc("lut_c1", 1, 0, 1, 0, 2'b00, 2'b00, 2);
        exp_cyc("lut_c2", 1, 0, 1, 0, 2'b00, 2'b00, 1);
        idle_inputs();
        exp_cyc("lut_done", 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // No hazard: load to r0, load with Rs unused, then plain ALU EX forward.
        rs_id = 7'd0; uses_rs = 1'b1; load_on(7'd0);
        exp_cyc("lu_r0", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        rs_id = 7'd5; uses_rs = 1'b0; load_on(7'd5);
        exp_cyc("lu_unused", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        uses_rs = 1'b1; mem_read_ex = 1'b0;
        exp_cyc("fwd_ex_a", 0, 0, 0, 0, 2'b10, 2'b00, 0);

        // EX beats MEM on operand B; MEM when EX stops writing.
        idle_inputs();
        rt_id = 7'd9; uses_rt = 1'b1; rd_ex = 7'd9; reg_write_ex = 1'b1;
        rd_mem = 7'd9; reg_write_mem = 1'b1;
        exp_cyc("fwd_b_ex", 0, 0, 0, 0, 2'b00, 2'b10, 0);
        reg_write_ex = 1'b0;
        exp_cyc("fwd_b_mem", 0, 0, 0, 0, 2'b00, 2'b01, 0);
        rd_mem = 7'd0;
        exp_cyc("fwd_b_r0", 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Taken branch overrides a load-use condition; no stall follows.
        idle_inputs();
        rs_id = 7'd5; uses_rs = 1'b1; load_on(7'd5); br_taken = 1'b1;
        exp_cyc("br_lu", 0, 0, 1, 1, 2'b00, 2'b00, 0);
        idle_inputs();
        exp_cyc("br_after", 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Full multiply stall; branch/load-use ignored while busy, forwarding still live.
        mul_start = 1'b1;
        exp_cyc("mul_c0", 1, 1, 0, 0, 2'b00, 2'b00, 0);
        mul_start = 1'b0; br_taken = 1'b1;
        rs_id = 7'd5; uses_rs = 1'b1; load_on(7'd5);
        rt_id = 7'd7; rd_mem = 7'd7; reg_write_mem = 1'b1;
        exp_cyc("mul_c1", 1, 1, 0, 0, 2'b00, 2'b01, 2);
        exp_cyc("mul_c2", 1, 1, 0, 0, 2'b00, 2'b01, 1);
        idle_inputs();
        exp_cyc("mul_done", 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Reset in the second multiply cycle aborts the stall.
        mul_start = 1'b1;
        exp_cyc("mulr_c0", 1, 1, 0, 0, 2'b00, 2'b00, 0);
        mul_start = 1'b0; rst_n = 1'b0;
        exp_cyc("mulr_rst", 1, 1, 0, 0, 2'b00, 2'b00, -1);
        idle_inputs();
        exp_cyc("mulr_rel", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        exp_cyc("mulr_rel2", 0, 0, 0, 0, 2'b00, 2'b00, 0);

        @(negedge clk);
        #1;
        check_eq("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
